pjdl_send_gen: RTL and testbench

- Second-generation PJDL transmitter for the PJON_ASIC physical layer. Generalises the existing single-byte sender.
- Parameters set the data word width, FIFO depth, number of frame-start sync pulses and timing-counter width.
- New over the previous generation: bus readback collision detection, frame abort with flushing of queued words, and explicit underrun handling.
- Fed by a valid/ready word stream from Layer 3 or a wrapper. Drives the tri-stated PJDL pin.

---
 rtl/pjdl_send_gen.sv | 256 +++++++++++++++++++++++++
 tb/tb_pjdl_send_gen.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pjdl_send_gen.sv
// PJDL frame transmitter: buffers a valid/ready word stream and serialises it as
// preamble, frame syncs, then word-sync + LSB-first data bits, with bus readback checking.
module pjdl_send_gen #(
  parameter int unsigned DataWidth       = 8,
  parameter int unsigned BufferDepth     = 4,
  parameter int unsigned NumFrameSyncs   = 3,
  parameter int unsigned CntWidth        = 20,
  parameter bit          CollisionDetect = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic                 in_last_i,
  input  logic [CntWidth-1:0]  pjdl_spec_preamble_i,
  input  logic [13:0]          pjdl_spec_pad_i,
  input  logic [11:0]          pjdl_spec_data_i,
  input  logic                 pjon_i,
  output logic                 pjon_o,
  output logic                 pjon_en_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 collision_o,
  output logic                 underrun_o
);

  localparam int unsigned PtrW  = (BufferDepth > 1) ? $clog2(BufferDepth) : 1;
  localparam int unsigned LvlW  = $clog2(BufferDepth + 1);
  localparam int unsigned BitW  = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam int unsigned SyncW = (NumFrameSyncs > 1) ? $clog2(NumFrameSyncs) : 1;
  localparam int unsigned EntW  = DataWidth + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_FRAME_SYNC,
    S_WORD_SYNC,
    S_DATA,
    S_ABORT
  } state_t;

  // ---------------------------------------------------------------- word FIFO
  logic [EntW-1:0] r_mem [BufferDepth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [LvlW-1:0] r_level;
  logic            r_pop;
  logic            w_full;
  logic            w_push;
  logic            w_empty_eff;
  logic [EntW-1:0] w_head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BufferDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign w_full      = (r_level == LvlW'(BufferDepth));
  assign in_ready_o  = !w_full && !rst_i;
  assign w_push      = in_valid_i && in_ready_o;
  assign w_head      = r_mem[r_rd_ptr];
  // A requested pop lands one cycle later; treat it as already gone.
  assign w_empty_eff = (r_level == LvlW'(r_pop));

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_last_i, in_data_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (r_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, r_pop})
        2'b10:   r_level <= r_level + LvlW'(1);
        2'b01:   r_level <= r_level - LvlW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // ------------------------------------------------------- sequencer registers
  state_t               r_state;
  logic [CntWidth-1:0]  r_cnt;
  logic                 r_phase;
  logic [SyncW-1:0]     r_sync_cnt;
  logic [BitW-1:0]      r_bit_cnt;
  logic [DataWidth-1:0] r_shift;
  logic                 r_last;

  state_t               w_state_nx;
  logic [CntWidth-1:0]  w_cnt_nx;
  logic                 w_phase_nx;
  logic [SyncW-1:0]     w_sync_nx;
  logic [BitW-1:0]      w_bit_nx;
  logic [DataWidth-1:0] w_shift_nx;
  logic                 w_last_nx;
  logic                 w_pop_req;

  logic [CntWidth-1:0]  w_limit;
  logic                 w_seg_end;
  logic                 w_active;
  logic                 w_drive;
  logic                 w_bit_last;
  logic                 w_word_end;
  logic                 w_col;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_sync_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_last     <= 1'b0;
      r_pop      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_phase    <= w_phase_nx;
      r_sync_cnt <= w_sync_nx;
      r_bit_cnt  <= w_bit_nx;
      r_shift    <= w_shift_nx;
      r_last     <= w_last_nx;
      r_pop      <= w_pop_req;
    end
  end

  // Segment length and the level the pin should carry in it.
  always_comb begin
    w_limit = CntWidth'(pjdl_spec_data_i);
    w_drive = 1'b0;
    case (r_state)
      S_PREAMBLE: begin
        w_limit = pjdl_spec_preamble_i;
        w_drive = 1'b1;
      end
      S_FRAME_SYNC, S_WORD_SYNC: begin
        if (!r_phase) w_limit = CntWidth'(pjdl_spec_pad_i);
        w_drive = !r_phase;
      end
      S_DATA:  w_drive = r_shift[0];
      default: w_drive = 1'b0;
    endcase
  end

  assign w_active   = (r_state == S_PREAMBLE) || (r_state == S_FRAME_SYNC) ||
                      (r_state == S_WORD_SYNC) || (r_state == S_DATA);
  assign w_seg_end  = (r_cnt == w_limit);
  assign w_bit_last = (r_bit_cnt == BitW'(DataWidth - 1));
  assign w_word_end = (r_state == S_DATA) && w_seg_end && w_bit_last;
  assign w_col      = CollisionDetect && w_active && enable_i && w_seg_end && (pjon_i != w_drive);

  // Next-state and datapath update.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_phase_nx = r_phase;
    w_sync_nx  = r_sync_cnt;
    w_bit_nx   = r_bit_cnt;
    w_shift_nx = r_shift;
    w_last_nx  = r_last;
    w_pop_req  = 1'b0;
    if (w_active) w_cnt_nx = w_seg_end ? '0 : r_cnt + CntWidth'(1);
    unique case (r_state)
      S_IDLE: begin
        if (enable_i && !r_pop && (r_level != '0)) begin
          w_state_nx = S_PREAMBLE;
          w_cnt_nx   = '0;
          w_phase_nx = 1'b0;
          w_sync_nx  = '0;
          w_bit_nx   = '0;
          w_last_nx  = 1'b0;
        end
      end
      S_ABORT: begin
        w_cnt_nx = '0;
        // Discard the rest of the aborted frame; stall while its tail is missing.
        if (r_last) begin
          w_state_nx = S_IDLE;
        end else if (!r_pop && (r_level != '0)) begin
          w_pop_req = 1'b1;
          if (w_head[DataWidth]) begin
            w_state_nx = S_IDLE;
            w_last_nx  = 1'b1;
          end
        end
      end
      default: begin
        if (!enable_i || w_col) begin
          w_state_nx = S_ABORT;
          w_cnt_nx   = '0;
        end else if (w_seg_end) begin
          case (r_state)
            S_PREAMBLE: begin
              w_state_nx = S_FRAME_SYNC;
              w_phase_nx = 1'b0;
              w_sync_nx  = '0;
            end
            S_FRAME_SYNC: begin
              w_phase_nx = !r_phase;
              if (r_phase) begin
                if (r_sync_cnt == SyncW'(NumFrameSyncs - 1)) w_state_nx = S_WORD_SYNC;
                else w_sync_nx = r_sync_cnt + SyncW'(1);
              end
            end
            S_WORD_SYNC: begin
              w_phase_nx = !r_phase;
              if (r_phase) begin
                w_state_nx = S_DATA;
                w_bit_nx   = '0;
                w_shift_nx = w_head[DataWidth-1:0];
                w_last_nx  = w_head[DataWidth];
                w_pop_req  = 1'b1;
              end
            end
            S_DATA: begin
              if (!w_bit_last) begin
                w_bit_nx   = r_bit_cnt + BitW'(1);
                w_shift_nx = r_shift >> 1;
              end else if (r_last) begin
                w_state_nx = S_IDLE;
              end else if (!w_empty_eff) begin
                w_state_nx = S_WORD_SYNC;
                w_phase_nx = 1'b0;
              end else begin
                w_state_nx = S_ABORT;
              end
            end
            default: w_state_nx = r_state;
          endcase
        end
      end
    endcase
  end

  // Pin drive and status; collision outranks completion and underrun.
  always_comb begin
    pjon_en_o    = w_active;
    pjon_o       = w_active && w_drive;
    busy_o       = (r_state != S_IDLE);
    collision_o  = w_col;
    frame_done_o = 1'b0;
    underrun_o   = 1'b0;
    if (w_word_end && enable_i && !w_col) begin
      frame_done_o = r_last;
      underrun_o   = !r_last && w_empty_eff;
    end
  end

endmodule

// File: tb/tb_pjdl_send_gen.sv
// Directed bench for pjdl_send_gen: loopback bus model with a jam override,
// pin capture into a queue, and hand-computed frame layouts.
module tb_pjdl_send_gen;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  in_data_i;
  logic        in_last_i;
  logic [19:0] pjdl_spec_preamble_i;
  logic [13:0] pjdl_spec_pad_i;
  logic [11:0] pjdl_spec_data_i;
  logic        pjon_i;
  logic        pjon_o;
  logic        pjon_en_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        collision_o;
  logic        underrun_o;

  logic        jam;
  int          checks = 0;
  int          errors = 0;
  int          n_done = 0;
  int          n_col  = 0;
  int          n_und  = 0;
  logic        q[$];

  pjdl_send_gen dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .enable_i            (enable_i),
    .in_valid_i          (in_valid_i),
    .in_ready_o          (in_ready_o),
    .in_data_i           (in_data_i),
    .in_last_i           (in_last_i),
    .pjdl_spec_preamble_i(pjdl_spec_preamble_i),
    .pjdl_spec_pad_i     (pjdl_spec_pad_i),
    .pjdl_spec_data_i    (pjdl_spec_data_i),
    .pjon_i              (pjon_i),
    .pjon_o              (pjon_o),
    .pjon_en_o           (pjon_en_o),
    .busy_o              (busy_o),
    .frame_done_o        (frame_done_o),
    .collision_o         (collision_o),
    .underrun_o          (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Bus reads back what is driven unless jammed low.
  assign pjon_i = jam ? 1'b0 : pjon_o;

  always @(negedge clk_i) begin
    if (pjon_en_o)    q.push_back(pjon_o);
    if (frame_done_o) n_done++;
    if (collision_o)  n_col++;
    if (underrun_o)   n_und++;
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = l;
    while (!in_ready_o && n < 50) begin
      tick;
      n++;
    end
    chk1("push_ready", in_ready_o, 1'b1);
    tick;
    in_valid_i = 1'b0;
  endtask

  // sel: 0 frame_done, 1 underrun, 2 pjon_en
  task automatic wait_sig(input int sel, input int max, input string tag);
    int   n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (n < max) begin
      case (sel)
        0:       hit = frame_done_o;
        1:       hit = underrun_o;
        default: hit = pjon_en_o;
      endcase
      if (hit) break;
      tick;
      n++;
    end
    chk1(tag, hit, 1'b1);
  endtask

  function automatic logic [7:0] decode(input int base);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = (base + 2 * k < q.size()) ? q[base + 2 * k] : 1'bx;
    return b;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int qs, qs2, d0, c0, u0;
    rst_i = 1'b1;
    enable_i = 1'b0;
    in_valid_i = 1'b0;
    in_data_i = '0;
    in_last_i = 1'b0;
    jam = 1'b0;
    pjdl_spec_preamble_i = 20'd9;
    pjdl_spec_pad_i = 14'd3;
    pjdl_spec_data_i = 12'd1;
    repeat (3) tick;
    chk1("rst_in_ready", in_ready_o, 1'b0);
    chk1("rst_pjon_en", pjon_en_o, 1'b0);
    chk1("rst_pjon", pjon_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_pulses", frame_done_o | collision_o | underrun_o, 1'b0);
    rst_i = 1'b0;
    tick;
    chk1("ready_after_reset", in_ready_o, 1'b1);

    // Single word 0xA5
    enable_i = 1'b1;
    qs = q.size();
    d0 = n_done;
    push(8'hA5, 1'b1);
    wait_sig(0, 300, "t1_done_seen");
    chk1("t1_busy_at_done", busy_o, 1'b1);
    tick;
    chk1("t1_busy_after", busy_o, 1'b0);
    chk1("t1_en_after", pjon_en_o, 1'b0);
    chk1("t1_pjon_after", pjon_o, 1'b0);
    chk("t1_en_cycles", 32'(q.size() - qs), 32'd50);
    chk("t1_preamble", 32'(q[qs]), 32'd1);
    chk("t1_sync_high", 32'(q[qs + 13]), 32'd1);
    chk("t1_sync_low", 32'(q[qs + 14]), 32'd0);
    chk("t1_data", 32'(decode(qs + 34)), 32'hA5);
    chk("t1_done_count", 32'(n_done - d0), 32'd1);

    // Three words back to back
    enable_i = 1'b0;
    push(8'h01, 1'b0);
    push(8'h80, 1'b0);
    push(8'hFF, 1'b1);
    qs = q.size();
    d0 = n_done;
    u0 = n_und;
    enable_i = 1'b1;
    wait_sig(0, 400, "t2_done_seen");
    tick;
    chk("t2_en_cycles", 32'(q.size() - qs), 32'd94);
    chk("t2_word0", 32'(decode(qs + 34)), 32'h01);
    chk("t2_word1", 32'(decode(qs + 56)), 32'h80);
    chk("t2_word2", 32'(decode(qs + 78)), 32'hFF);
    chk("t2_done_count", 32'(n_done - d0), 32'd1);
    chk("t2_no_underrun", 32'(n_und - u0), 32'd0);

    // Collision on first data bit of 0x11, then frame 0x44
    enable_i = 1'b0;
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b1);
    push(8'h44, 1'b1);
    qs = q.size();
    d0 = n_done;
    c0 = n_col;
    enable_i = 1'b1;
    wait_sig(2, 50, "t3_start");
    repeat (34) tick;
    jam = 1'b1;
    chk1("t3_bit0_high", pjon_o, 1'b1);
    chk1("t3_no_col_early", collision_o, 1'b0);
    tick;
    chk1("t3_collision", collision_o, 1'b1);
    tick;
    jam = 1'b0;
    chk1("t3_en_dropped", pjon_en_o, 1'b0);
    chk1("t3_busy_abort", busy_o, 1'b1);
    qs2 = q.size();
    chk("t3_cut_length", 32'(qs2 - qs), 32'd36);
    wait_sig(0, 400, "t3_done_seen");
    tick;
    chk("t3_resend_cycles", 32'(q.size() - qs2), 32'd50);
    chk("t3_resend_word", 32'(decode(qs2 + 34)), 32'h44);
    chk("t3_col_count", 32'(n_col - c0), 32'd1);
    chk("t3_done_count", 32'(n_done - d0), 32'd1);

    // Underrun
    u0 = n_und;
    d0 = n_done;
    push(8'h10, 1'b0);
    wait_sig(1, 300, "t4_underrun_seen");
    tick;
    chk1("t4_en_dropped", pjon_en_o, 1'b0);
    chk1("t4_busy_abort", busy_o, 1'b1);
    repeat (5) tick;
    chk1("t4_stalled", busy_o, 1'b1);
    push(8'h20, 1'b1);
    repeat (2) tick;
    chk1("t4_idle", busy_o, 1'b0);
    qs = q.size();
    repeat (20) tick;
    chk("t4_no_tx", 32'(q.size() - qs), 32'd0);
    chk("t4_und_count", 32'(n_und - u0), 32'd1);
    chk("t4_no_done", 32'(n_done - d0), 32'd0);

    // enable_i dropped mid-preamble
    d0 = n_done;
    c0 = n_col;
    u0 = n_und;
    push(8'h5A, 1'b1);
    wait_sig(2, 50, "t5_start");
    repeat (3) tick;
    enable_i = 1'b0;
    chk1("t5_en_still", pjon_en_o, 1'b1);
    tick;
    chk1("t5_en_dropped", pjon_en_o, 1'b0);
    repeat (4) tick;
    chk1("t5_idle", busy_o, 1'b0);
    enable_i = 1'b1;
    repeat (3) tick;
    chk1("t5_flushed", busy_o, 1'b0);
    chk("t5_no_pulses", 32'((n_done - d0) + (n_col - c0) + (n_und - u0)), 32'd0);
    qs = q.size();
    push(8'hC3, 1'b1);
    wait_sig(0, 300, "t5_done_seen");
    tick;
    chk("t5_en_cycles", 32'(q.size() - qs), 32'd50);
    chk("t5_data", 32'(decode(qs + 34)), 32'hC3);

    // FIFO full, then reset mid-frame
    enable_i = 1'b0;
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    push(8'h04, 1'b1);
    chk1("t6_full", in_ready_o, 1'b0);
    in_valid_i = 1'b1;
    in_data_i = 8'h05;
    repeat (3) tick;
    chk1("t6_still_full", in_ready_o, 1'b0);
    chk1("t6_not_busy", busy_o, 1'b0);
    in_valid_i = 1'b0;
    enable_i = 1'b1;
    wait_sig(2, 50, "t6_start");
    repeat (20) tick;
    #2;
    rst_i = 1'b1;
    #1;
    chk1("t6_rst_en", pjon_en_o, 1'b0);
    chk1("t6_rst_pjon", pjon_o, 1'b0);
    chk1("t6_rst_busy", busy_o, 1'b0);
    chk1("t6_rst_ready", in_ready_o, 1'b0);
    tick;
    rst_i = 1'b0;
    tick;
    chk1("t6_ready_again", in_ready_o, 1'b1);
    repeat (5) tick;
    chk1("t6_fifo_lost", busy_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
